// File: rtl/mem_arb_pkg.sv
// Shared types and default widths for the memory access arbiter.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } state_t;

  localparam int NUM_REQ_DEF = 2;
  localparam int ADDR_W_DEF  = 2;
  localparam int DATA_W_DEF  = 8;
  localparam int RD_LAT_DEF  = 1;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin grant selection with a rotating priority pointer.
// The pointer names the requester with highest priority; it moves to one past
// the winner only when the grant is actually taken (advance).
module rr_arbiter #(
  parameter int N = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [N-1:0] req,
  input  logic         advance,
  output logic [N-1:0] gnt
);

  localparam int PW = (N > 1) ? $clog2(N) : 1;

  logic [PW-1:0] ptr_q;
  logic [PW-1:0] ptr_d;
  logic          found;

  // Pick the first requester at or above the pointer, else wrap to the lowest one.
  always_comb begin
    gnt   = '0;
    ptr_d = ptr_q;
    found = 1'b0;
    for (int j = 0; j < N; j++) begin
      if (!found && req[j] && (j >= int'(ptr_q))) begin
        found  = 1'b1;
        gnt[j] = 1'b1;
        ptr_d  = (j == N - 1) ? '0 : PW'(j + 1);
      end
    end
    for (int j = 0; j < N; j++) begin
      if (!found && req[j] && (j < int'(ptr_q))) begin
        found  = 1'b1;
        gnt[j] = 1'b1;
        ptr_d  = (j == N - 1) ? '0 : PW'(j + 1);
      end
    end
    if (!advance) begin
      ptr_d = ptr_q;
    end
  end

  // Pointer register; reset favours requester 0.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr_q <= '0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

endmodule

// File: rtl/mem_access_arbiter.sv
// Shares one single-port memory between NUM_REQ requesters, one access at a
// time, and returns a one-cycle response pulse (with read data) to the owner.
module mem_access_arbiter
  import mem_arb_pkg::*;
#(
  parameter int NUM_REQ = NUM_REQ_DEF,
  parameter int ADDR_W  = ADDR_W_DEF,
  parameter int DATA_W  = DATA_W_DEF,
  parameter int RD_LAT  = RD_LAT_DEF
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUM_REQ-1:0]        req_valid,
  output logic [NUM_REQ-1:0]        req_ready,
  input  logic [NUM_REQ-1:0]        req_wr,
  input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
  input  logic [NUM_REQ*DATA_W-1:0] req_wdata,
  output logic [NUM_REQ-1:0]        rsp_valid,
  output logic [DATA_W-1:0]         rsp_rdata,
  output logic [ADDR_W-1:0]         mem_addr,
  output logic                      mem_wr_en,
  output logic                      mem_rd_en,
  output logic [DATA_W-1:0]         mem_wdata,
  input  logic [DATA_W-1:0]         mem_rdata
);

  localparam int                CNT_W    = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(RD_LAT - 1);

  state_t               state_q, state_d;
  logic [NUM_REQ-1:0]   owner_q, owner_d;
  logic                 wr_q, wr_d;
  logic [ADDR_W-1:0]    mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0]    mem_wdata_q, mem_wdata_d;
  logic                 mem_wr_en_q, mem_wr_en_d;
  logic                 mem_rd_en_q, mem_rd_en_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [NUM_REQ-1:0]   rsp_valid_q, rsp_valid_d;
  logic [DATA_W-1:0]    rsp_rdata_q, rsp_rdata_d;

  logic [NUM_REQ-1:0]   gnt;
  logic                 advance;

  // A handshake happens whenever something is valid while idle, since ready is combinational.
  assign advance   = (state_q == IDLE) && (|req_valid);
  assign req_ready = (state_q == IDLE) ? gnt : '0;

  rr_arbiter #(
    .N (NUM_REQ)
  ) u_rr (
    .clk     (clk),
    .rst     (rst),
    .req     (req_valid),
    .advance (advance),
    .gnt     (gnt)
  );

  // Next-state and registered-output computation for the access sequencer.
  always_comb begin
    state_d     = state_q;
    owner_d     = owner_q;
    wr_d        = wr_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    mem_wr_en_d = 1'b0;
    mem_rd_en_d = 1'b0;
    cnt_d       = cnt_q;
    rsp_valid_d = '0;
    rsp_rdata_d = rsp_rdata_q;
    case (state_q)
      IDLE: begin
        if (advance) begin
          owner_d = gnt;
          for (int r = 0; r < NUM_REQ; r++) begin
            if (gnt[r]) begin
              wr_d        = req_wr[r];
              mem_addr_d  = req_addr[r*ADDR_W +: ADDR_W];
              mem_wdata_d = req_wdata[r*DATA_W +: DATA_W];
            end
          end
          mem_wr_en_d = wr_d;
          mem_rd_en_d = !wr_d;
          // A write completes in the cycle its enable is on the pins.
          if (wr_d) begin
            rsp_valid_d = gnt;
          end
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        cnt_d   = '0;
        state_d = wr_q ? IDLE : WAIT;
      end
      WAIT: begin
        if (cnt_q == CNT_LAST) begin
          rsp_valid_d = owner_q;
          rsp_rdata_d = mem_rdata;
          state_d     = RESP;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      RESP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and output registers; reset aborts any access in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      owner_q     <= '0;
      wr_q        <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      mem_wr_en_q <= 1'b0;
      mem_rd_en_q <= 1'b0;
      cnt_q       <= '0;
      rsp_valid_q <= '0;
      rsp_rdata_q <= '0;
    end else begin
      state_q     <= state_d;
      owner_q     <= owner_d;
      wr_q        <= wr_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      mem_wr_en_q <= mem_wr_en_d;
      mem_rd_en_q <= mem_rd_en_d;
      cnt_q       <= cnt_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
    end
  end

  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign mem_wr_en = mem_wr_en_q;
  assign mem_rd_en = mem_rd_en_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;

endmodule

// File: tb/tb_mem_access_arbiter.sv
// Scoreboard bench for mem_access_arbiter: a default RD_LAT=1 instance driven by
// two requester processes, plus an RD_LAT=3 instance for the long-latency case.
module tb_mem_access_arbiter;

  localparam int N  = 2;
  localparam int AW = 2;
  localparam int DW = 8;

  logic clk = 1'b0;
  logic rst;
  int   cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Default-latency instance.
  logic [N-1:0]    req_valid, req_ready, req_wr, rsp_valid;
  logic [N*AW-1:0] req_addr;
  logic [N*DW-1:0] req_wdata;
  logic [DW-1:0]   rsp_rdata, mem_wdata, mem_rdata;
  logic [AW-1:0]   mem_addr;
  logic            mem_wr_en, mem_rd_en;

  mem_access_arbiter #(.NUM_REQ(N), .ADDR_W(AW), .DATA_W(DW), .RD_LAT(1)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .req_wr(req_wr), .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .mem_addr(mem_addr),
    .mem_wr_en(mem_wr_en), .mem_rd_en(mem_rd_en), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata));

  logic [DW-1:0] mem [4];
  logic [DW-1:0] rd_pipe;
  always @(posedge clk) begin
    if (mem_wr_en) mem[mem_addr] <= mem_wdata;
    if (mem_rd_en) rd_pipe <= mem[mem_addr];
  end
  assign mem_rdata = rd_pipe;

  // RD_LAT=3 instance.
  logic [N-1:0]    b_req_valid, b_req_ready, b_req_wr, b_rsp_valid;
  logic [N*AW-1:0] b_req_addr;
  logic [N*DW-1:0] b_req_wdata;
  logic [DW-1:0]   b_rsp_rdata, b_mem_wdata, b_mem_rdata;
  logic [AW-1:0]   b_mem_addr;
  logic            b_mem_wr_en, b_mem_rd_en;

  mem_access_arbiter #(.NUM_REQ(N), .ADDR_W(AW), .DATA_W(DW), .RD_LAT(3)) dut3 (
    .clk(clk), .rst(rst), .req_valid(b_req_valid), .req_ready(b_req_ready),
    .req_wr(b_req_wr), .req_addr(b_req_addr), .req_wdata(b_req_wdata),
    .rsp_valid(b_rsp_valid), .rsp_rdata(b_rsp_rdata), .mem_addr(b_mem_addr),
    .mem_wr_en(b_mem_wr_en), .mem_rd_en(b_mem_rd_en), .mem_wdata(b_mem_wdata),
    .mem_rdata(b_mem_rdata));

  logic [DW-1:0] b_mem [4];
  logic [DW-1:0] b_pipe [3];
  always @(posedge clk) begin
    if (b_mem_wr_en) b_mem[b_mem_addr] <= b_mem_wdata;
    if (b_mem_rd_en) b_pipe[0] <= b_mem[b_mem_addr];
    b_pipe[1] <= b_pipe[0];
    b_pipe[2] <= b_pipe[1];
  end
  assign b_mem_rdata = b_pipe[2];

  // Scoreboard.
  typedef struct {
    int            owner;
    bit            wr;
    logic [DW-1:0] data;
    int            due;
  } exp_t;

  exp_t          sbq[$];
  int            grant_log[$];
  logic [DW-1:0] last_rd;
  int            vectors = 0;
  int            miscompares = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic fail_now(input string name);
    vectors++;
    miscompares++;
    $display("FAIL %s (cycle %0d)", name, cyc);
  endtask

  // Monitor: per-cycle invariants, grant logging and response checking.
  always @(negedge clk) begin
    if (!rst) begin
      chk("wr_rd_exclusive", 32'(mem_wr_en && mem_rd_en), 32'd0);
      chk("ready_onehot0", 32'($onehot0(req_ready)), 32'd1);
      chk("rsp_onehot0", 32'($onehot0(rsp_valid)), 32'd1);
      chk("b_wr_rd_exclusive", 32'(b_mem_wr_en && b_mem_rd_en), 32'd0);
      if (|req_ready)
        chk("ready_only_in_idle", {29'd0, mem_wr_en, mem_rd_en, |rsp_valid}, 32'd0);
      for (int i = 0; i < N; i++)
        if (req_ready[i] && req_valid[i]) grant_log.push_back(i);
      if (|rsp_valid) begin
        if (sbq.size() == 0) begin
          fail_now("rsp_unexpected");
        end else begin
          exp_t e;
          e = sbq.pop_front();
          chk("rsp_owner", 32'(rsp_valid), 32'(1 << e.owner));
          chk("rsp_cycle", 32'(cyc), 32'(e.due));
          if (!e.wr) last_rd = e.data;
          chk("rsp_rdata", 32'(rsp_rdata), 32'(last_rd));
        end
      end
    end
  end

  // One request on the default instance; pushes its expected response on acceptance.
  task automatic do_req(input int r, input bit wr, input logic [AW-1:0] a,
                        input logic [DW-1:0] d, input logic [DW-1:0] exp_d);
    int   waited;
    exp_t e;
    waited = 0;
    req_wr[r] = wr;
    req_addr[r*AW +: AW] = a;
    req_wdata[r*DW +: DW] = d;
    req_valid[r] = 1'b1;
    do begin
      @(negedge clk);
      waited++;
    end while (!req_ready[r] && waited < 50);
    if (!req_ready[r]) begin
      fail_now("grant_timeout");
      req_valid[r] = 1'b0;
      return;
    end
    e.owner = r;
    e.wr    = wr;
    e.data  = exp_d;
    e.due   = wr ? cyc + 1 : cyc + 3;
    sbq.push_back(e);
    @(posedge clk);
    #1 req_valid[r] = 1'b0;
    @(negedge clk);
    chk("issue_wr_en", 32'(mem_wr_en), 32'(wr));
    chk("issue_rd_en", 32'(mem_rd_en), 32'(!wr));
    chk("issue_addr", 32'(mem_addr), 32'(a));
    if (wr) chk("issue_wdata", 32'(mem_wdata), 32'(d));
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_req_ready"}, 32'(req_ready), 32'd0);
    chk({tag, "_rsp_valid"}, 32'(rsp_valid), 32'd0);
    chk({tag, "_mem_en"}, {30'd0, mem_wr_en, mem_rd_en}, 32'd0);
    chk({tag, "_mem_addr"}, 32'(mem_addr), 32'd0);
    chk({tag, "_mem_wdata"}, 32'(mem_wdata), 32'd0);
    chk({tag, "_rsp_rdata"}, 32'(rsp_rdata), 32'd0);
  endtask

  task automatic apply_reset();
    repeat (6) @(posedge clk);
    chk("sbq_drained", 32'(sbq.size()), 32'd0);
    #1 rst = 1'b1;
    last_rd = '0;
    sbq.delete();
    #1 check_reset_outputs("reset");
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  // One request on the RD_LAT=3 instance, checked inline over a fixed window.
  task automatic b_do(input bit wr, input logic [AW-1:0] a, input logic [DW-1:0] d,
                      input logic [DW-1:0] exp_d);
    int t, waited, rd_cnt, rd_cyc, rsp_cnt, rsp_cyc;
    waited = 0; rd_cnt = 0; rd_cyc = -1; rsp_cnt = 0; rsp_cyc = -1;
    b_req_wr[0] = wr;
    b_req_addr[AW-1:0] = a;
    b_req_wdata[DW-1:0] = d;
    b_req_valid[0] = 1'b1;
    do begin
      @(negedge clk);
      waited++;
    end while (!b_req_ready[0] && waited < 50);
    if (!b_req_ready[0]) begin
      fail_now("b_grant_timeout");
      b_req_valid[0] = 1'b0;
      return;
    end
    t = cyc;
    @(posedge clk);
    #1 b_req_valid[0] = 1'b0;
    repeat (10) begin
      @(negedge clk);
      if (b_mem_rd_en) begin rd_cnt++; rd_cyc = cyc; end
      if (|b_rsp_valid) begin
        rsp_cnt++;
        rsp_cyc = cyc;
        chk("b_rsp_owner", 32'(b_rsp_valid), 32'd1);
        chk("b_rsp_rdata", 32'(b_rsp_rdata), 32'(exp_d));
      end
    end
    chk("b_rsp_count", 32'(rsp_cnt), 32'd1);
    chk("b_rsp_cycle", 32'(rsp_cyc), wr ? 32'(t + 1) : 32'(t + 5));
    chk("b_rd_en_count", 32'(rd_cnt), wr ? 32'd0 : 32'd1);
    if (!wr) chk("b_rd_en_cycle", 32'(rd_cyc), 32'(t + 1));
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int waited;
    rst = 1'b1;
    req_valid = '0; req_wr = '0; req_addr = '0; req_wdata = '0;
    b_req_valid = '0; b_req_wr = '0; b_req_addr = '0; b_req_wdata = '0;
    last_rd = '0;
    repeat (2) @(posedge clk);
    #1 check_reset_outputs("por");
    rst = 1'b0;

    // Test 1: write then read back on requester 0.
    do_req(0, 1'b1, 2'd2, 8'hA5, 8'h00);
    do_req(0, 1'b0, 2'd2, 8'h00, 8'hA5);

    // Test 2: both requesters reading continuously alternate.
    apply_reset();
    do_req(0, 1'b1, 2'd0, 8'h11, 8'h00);
    do_req(1, 1'b1, 2'd1, 8'h22, 8'h00);
    repeat (2) @(posedge clk);
    #1 grant_log.delete();
    fork
      begin
        do_req(0, 1'b0, 2'd0, 8'h00, 8'h11);
        do_req(0, 1'b0, 2'd0, 8'h00, 8'h11);
      end
      begin
        do_req(1, 1'b0, 2'd1, 8'h00, 8'h22);
        do_req(1, 1'b0, 2'd1, 8'h00, 8'h22);
      end
    join
    chk("t2_grant_count", 32'(grant_log.size()), 32'd4);
    if (grant_log.size() == 4) begin
      chk("t2_grant0", 32'(grant_log[0]), 32'd0);
      chk("t2_grant1", 32'(grant_log[1]), 32'd1);
      chk("t2_grant2", 32'(grant_log[2]), 32'd0);
      chk("t2_grant3", 32'(grant_log[3]), 32'd1);
    end

    // Test 3: lone requester 1, back-to-back writes then reads.
    apply_reset();
    for (int i = 0; i < 4; i++) do_req(1, 1'b1, 2'(i), 8'(8'h10 + i), 8'h00);
    for (int i = 0; i < 4; i++) do_req(1, 1'b0, 2'(i), 8'h00, 8'(8'h10 + i));
    repeat (6) @(posedge clk);
    chk("t3_sbq_drained", 32'(sbq.size()), 32'd0);

    // Test 4: reset during WAIT of a read aborts it.
    #1;
    req_wr[0] = 1'b0; req_addr[AW-1:0] = 2'd3; req_valid[0] = 1'b1;
    waited = 0;
    do begin
      @(negedge clk);
      waited++;
    end while (!req_ready[0] && waited < 50);
    chk("t4_accepted", 32'(req_ready[0]), 32'd1);
    @(posedge clk);
    #1 req_valid[0] = 1'b0;
    @(posedge clk);
    #1 rst = 1'b1;
    last_rd = '0;
    #1 check_reset_outputs("t4_abort");
    repeat (3) begin
      @(negedge clk);
      chk("t4_rsp_in_reset", 32'(rsp_valid), 32'd0);
    end
    @(posedge clk);
    #1 rst = 1'b0;
    grant_log.delete();
    fork
      do_req(0, 1'b0, 2'd3, 8'h00, 8'h13);
      do_req(1, 1'b0, 2'd2, 8'h00, 8'h12);
    join
    repeat (6) @(posedge clk);
    chk("t4_grant_count", 32'(grant_log.size()), 32'd2);
    if (grant_log.size() == 2) begin
      chk("t4_first_grant", 32'(grant_log[0]), 32'd0);
      chk("t4_second_grant", 32'(grant_log[1]), 32'd1);
    end
    chk("t4_sbq_drained", 32'(sbq.size()), 32'd0);

    // Test 5: RD_LAT=3 instance.
    @(posedge clk);
    #1 b_do(1'b1, 2'd1, 8'h3C, 8'h00);
    b_do(1'b0, 2'd1, 8'h00, 8'h3C);

    repeat (4) @(posedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
